// File: rtl/matriz_scan_driver.sv
// Row-multiplexed scan driver for a 6x6 LED matrix: latches one frame per scan
// and drives it row by row with a blanking gap between rows.
module matriz_scan_driver #(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned BLANK = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [35:0] leds,
  output logic [5:0]  row_sel,
  output logic [5:0]  col,
  output logic [2:0]  row_idx,
  output logic        frame_start
);

  localparam int unsigned MAX_LEN = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int          CNT_W   = $clog2(MAX_LEN + 1);

  // The counter holds the cycles remaining after the current one.
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_BLANK,
    S_ON
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [35:0]       frame_buf_q, frame_buf_d;
  logic [2:0]        row_idx_q, row_idx_d;
  logic [5:0]        row_sel_q, row_sel_d;
  logic [5:0]        col_q, col_d;
  logic              frame_start_q, frame_start_d;

  function automatic logic [5:0] one_hot(input logic [2:0] r);
    case (r)
      3'd0:    return 6'b000001;
      3'd1:    return 6'b000010;
      3'd2:    return 6'b000100;
      3'd3:    return 6'b001000;
      3'd4:    return 6'b010000;
      3'd5:    return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] row_bits(input logic [35:0] f, input logic [2:0] r);
    case (r)
      3'd0:    return f[5:0];
      3'd1:    return f[11:6];
      3'd2:    return f[17:12];
      3'd3:    return f[23:18];
      3'd4:    return f[29:24];
      3'd5:    return f[35:30];
      default: return 6'b000000;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_buf_d = frame_buf_q;
    row_idx_d   = row_idx_q;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_LATCH;
      end
      S_LATCH: begin
        frame_buf_d = leds;
        row_idx_d   = 3'd0;
        cnt_d       = BLANK_LOAD;
        state_d     = S_BLANK;
      end
      S_BLANK: begin
        if (cnt_q == '0) begin
          cnt_d   = DWELL_LOAD;
          state_d = S_ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ON: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (row_idx_q < 3'd5) begin
          row_idx_d = row_idx_q + 3'd1;
          cnt_d     = BLANK_LOAD;
          state_d   = S_BLANK;
        end else begin
          // Frame boundary: the only point where enable is honoured mid-scan.
          cnt_d   = '0;
          state_d = enable ? S_LATCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are computed from the next state so the registers line up with it.
    row_sel_d     = (state_d == S_ON) ? one_hot(row_idx_d) : 6'b000000;
    col_d         = (state_d == S_ON) ? row_bits(frame_buf_d, row_idx_d) : 6'b000000;
    frame_start_d = (state_q == S_LATCH);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      // NOTE: the frame buffer is reset too, so a frame never shows stale
      // power-up contents; it is small flop storage, not a RAM.
      frame_buf_q   <= '0;
      row_idx_q     <= 3'd0;
      row_sel_q     <= 6'b000000;
      col_q         <= 6'b000000;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_buf_q   <= frame_buf_d;
      row_idx_q     <= row_idx_d;
      row_sel_q     <= row_sel_d;
      col_q         <= col_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign row_sel     = row_sel_q;
  assign col         = col_q;
  assign row_idx     = row_idx_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/matriz_scan_driver.md
Name: matriz_scan_driver

Overview:
- Display-side reader of the 36-bit snake-game LED frame (6x6 matrix, row r = leds[6r+5:6r], column c = bit 6r+c).
- Scans the frame onto a physically multiplexed 6x6 LED matrix, one row at a time, with a blanking gap between rows to prevent ghosting.
- Latches the whole frame once per scan, at the frame boundary, so game updates never tear a frame.

Parameters:
- DWELL, 1000, clock cycles each row is driven on (>=1).
- BLANK, 8, clock cycles all rows and columns are off between rows (>=1).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  scan enable; sampled only at frame boundaries.
- leds  input  36  frame from the LED-matrix generator; bit 6r+c = row r, column c.
- row_sel  output  6  one-hot row drive, active-high; bit r = row r.
- col  output  6  column drive, active-high; bit c = column c of the active row.
- row_idx  output  3  index of the row currently scanned (0..5).
- frame_start  output  1  one-cycle pulse marking the first cycle of each frame.

Behaviour:
- Single clock domain. All outputs are registered.
- Reset is asynchronous, active-high. It forces, without waiting for a clock edge:
  - state=IDLE; row_sel=0; col=0; row_idx=0; frame_start=0.
  - frame buffer=0; cycle counter=0.
- State machine (IDLE, LATCH, BLANK, ON):
  - IDLE: row_sel=0, col=0. Moves to LATCH on the first clock edge with enable=1.
  - LATCH (1 cycle): loads frame_buf <= leds and row_idx <= 0, then moves to BLANK.
  - BLANK (exactly BLANK cycles): row_sel=0, col=0. Then moves to ON.
  - ON (exactly DWELL cycles): row_sel = one-hot(row_idx); col = frame_buf[6*row_idx +: 6]. At the end of DWELL:
    - if row_idx<5: row_idx increments and the block goes to BLANK;
    - if row_idx==5 and enable=1: goes to LATCH (next frame);
    - if row_idx==5 and enable=0: goes to IDLE.
- frame_start is high for exactly the first BLANK cycle of row 0; it is low at all other times.
- Frame period = 1 + 6*(BLANK+DWELL) cycles, with no idle cycles between back-to-back frames.
- At most one row_sel bit is ever high. row_sel and col are never nonzero outside ON.
- Changes on leds between latches have no effect on outputs until the next LATCH.
- enable deasserted mid-frame: the current frame completes all 6 rows, then the block goes to IDLE. enable reasserted before row 5 ends: continuous scan, no gap.
- Reset asserted mid-row: outputs go to 0 immediately. After release with enable=1, the scan restarts at LATCH / row 0.
- Cycle counter width is clog2(max(DWELL,BLANK)+1). The counter reloads at each state entry and never wraps inside a state.
- row_idx wraps 5 -> 0 only via LATCH; values 6 and 7 are unreachable.

Test Plan (DWELL=4, BLANK=2, frame period 37):
- Reset, then enable=0 for 20 cycles -> row_sel=0, col=0, frame_start=0 throughout.
- Border frame (rows 0 and 5 = 6'b111111, rows 1-4 = 6'b100001), enable=1 -> sequence is 1 LATCH cycle, 2 blank cycles, then row_sel=000001 with col=111111 for 4 cycles. Each following row gets 2 blank cycles, then 4 cycles of:
  - rows 1-4: row_sel=000010..010000 with col=100001;
  - row 5: row_sel=100000 with col=111111.
  frame_start pulses every 37 cycles.
- Set leds[14] (row 2, column 2) while row 1 is active -> row 2 in this frame shows col=100001. Row 2 in the next frame shows col=100101.
- Drop enable during row 3 -> rows 3, 4 and 5 still complete; then outputs stay 0 with no further frame_start. Reassert enable -> LATCH follows on the next edge.
- Assert reset asynchronously mid-ON of row 2 -> row_sel, col and row_idx are 0 before the next clock edge. Release with enable=1 -> frame_start occurs 2 cycles after release edge (LATCH, then first BLANK).
- Over 3 full frames, check every cycle -> popcount(row_sel)<=1; exactly 2 zero cycles between consecutive rows; col=0 whenever row_sel=0.
